// File: rtl/pump_ctrl_pkg.sv
// Shared pump-control constants and the per-channel ramp state encoding.
// The duty stepping helper is used by every ramp channel.
package pump_ctrl_pkg;

   localparam logic [7:0] PWM_MIN = 8'd77;
   localparam logic [7:0] PWM_MAX = 8'd230;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RAMP    = 2'd1,
      HOLD    = 2'd2,
      LOCKOUT = 2'd3
   } ramp_state_t;

   // One step of cur toward tgt, clamped at tgt; 9-bit math keeps 255 and 0 from wrapping.
   function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                              input logic [7:0] tgt,
                                              input logic [7:0] step);
      logic [8:0] sum;
      logic [8:0] diff;
      sum  = {1'b0, cur} + {1'b0, step};
      diff = {1'b0, cur} - {1'b0, step};
      if (cur < tgt) begin
         return (sum > {1'b0, tgt}) ? tgt : sum[7:0];
      end else if (cur > tgt) begin
         return (diff[8] || (diff < {1'b0, tgt})) ? tgt : diff[7:0];
      end else begin
         return cur;
      end
   endfunction

endpackage

// File: rtl/pump_ramp_channel.sv
// One pump channel: rate-limited ramp toward the requested duty, immediate cut
// on stop/inhibit, then a fixed off-time lockout before the next restart.
module pump_ramp_channel
   import pump_ctrl_pkg::*;
#(
   parameter logic [7:0]  STEP_SIZE      = 8'd4,
   parameter logic [7:0]  START_DUTY     = PWM_MIN,
   parameter int unsigned MIN_OFF_CYCLES = 100_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       step_tick,
   input  logic [7:0] req_duty,
   input  logic       inhibit,
   output logic [7:0] duty,
   output logic       running,
   output logic       lockout,
   output logic       at_target
);

   localparam int unsigned    OFF_W    = (MIN_OFF_CYCLES > 1) ? $clog2(MIN_OFF_CYCLES) : 1;
   localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(MIN_OFF_CYCLES - 1);

   ramp_state_t       state, state_n;
   logic [7:0]        duty_n;
   logic [OFF_W-1:0]  off_cnt, off_cnt_n;
   logic              stop;

   assign stop = inhibit || (req_duty == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         duty    <= '0;
         off_cnt <= '0;
      end else begin
         state   <= state_n;
         duty    <= duty_n;
         off_cnt <= off_cnt_n;
      end
   end

   always_comb begin
      state_n   = state;
      duty_n    = duty;
      off_cnt_n = off_cnt;
      case (state)
         IDLE: begin
            duty_n = '0;
            if (!stop) begin
               state_n = RAMP;
               duty_n  = (req_duty < START_DUTY) ? req_duty : START_DUTY;
            end
         end
         RAMP: begin
            if (stop) begin
               state_n   = LOCKOUT;
               duty_n    = '0;
               off_cnt_n = '0;
            end else if (duty == req_duty) begin
               state_n = HOLD;
            end else if (step_tick) begin
               duty_n = step_toward(duty, req_duty, STEP_SIZE);
            end
         end
         HOLD: begin
            if (stop) begin
               state_n   = LOCKOUT;
               duty_n    = '0;
               off_cnt_n = '0;
            end else if (duty != req_duty) begin
               state_n = RAMP;
            end
         end
         LOCKOUT: begin
            duty_n = '0;
            if (off_cnt == OFF_LAST) begin
               state_n   = IDLE;
               off_cnt_n = '0;
            end else begin
               off_cnt_n = off_cnt + OFF_W'(1);
            end
         end
         default: begin
            state_n   = IDLE;
            duty_n    = '0;
            off_cnt_n = '0;
         end
      endcase
   end

   always_comb begin
      running   = (state == RAMP) || (state == HOLD);
      lockout   = (state == LOCKOUT);
      at_target = (state == HOLD);
   end

endmodule

// File: rtl/pump_ramp_scheduler.sv
// Applied-duty scheduler for the fill (A) and drain (B) pumps: a shared step
// prescaler feeding two independent ramp/lockout channels.
module pump_ramp_scheduler
   import pump_ctrl_pkg::*;
#(
   parameter int unsigned STEP_CYCLES    = 500_000,
   parameter logic [7:0]  STEP_SIZE      = 8'd4,
   parameter logic [7:0]  START_DUTY     = PWM_MIN,
   parameter int unsigned MIN_OFF_CYCLES = 100_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] req_duty_a,
   input  logic [7:0] req_duty_b,
   input  logic       inhibit_a,
   input  logic       inhibit_b,
   output logic [7:0] duty_a,
   output logic [7:0] duty_b,
   output logic       running_a,
   output logic       running_b,
   output logic       lockout_a,
   output logic       lockout_b,
   output logic       at_target_a,
   output logic       at_target_b
);

   localparam int unsigned      PRE_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_CYCLES - 1);

   logic [PRE_W-1:0] pre_cnt;
   logic             step_tick;

   assign step_tick = (pre_cnt == PRE_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt <= '0;
      end else if (step_tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   pump_ramp_channel #(
      .STEP_SIZE      (STEP_SIZE),
      .START_DUTY     (START_DUTY),
      .MIN_OFF_CYCLES (MIN_OFF_CYCLES)
   ) u_chan_a (
      .clk       (clk),
      .reset     (reset),
      .step_tick (step_tick),
      .req_duty  (req_duty_a),
      .inhibit   (inhibit_a),
      .duty      (duty_a),
      .running   (running_a),
      .lockout   (lockout_a),
      .at_target (at_target_a)
   );

   pump_ramp_channel #(
      .STEP_SIZE      (STEP_SIZE),
      .START_DUTY     (START_DUTY),
      .MIN_OFF_CYCLES (MIN_OFF_CYCLES)
   ) u_chan_b (
      .clk       (clk),
      .reset     (reset),
      .step_tick (step_tick),
      .req_duty  (req_duty_b),
      .inhibit   (inhibit_b),
      .duty      (duty_b),
      .running   (running_b),
      .lockout   (lockout_b),
      .at_target (at_target_b)
   );

endmodule

// File: tb/tb_pump_ramp_scheduler.sv
// Scoreboard bench for pump_ramp_scheduler: stimulus queues the expected outputs
// for the coming clock edge; a monitor pops and compares after each edge.
module tb_pump_ramp_scheduler;

   localparam int unsigned STEP_CYCLES = 4;
   localparam int unsigned MIN_OFF     = 20;

   localparam logic [2:0] F_IDLE = 3'b000;
   localparam logic [2:0] F_RAMP = 3'b100;
   localparam logic [2:0] F_HOLD = 3'b101;
   localparam logic [2:0] F_LOCK = 3'b010;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] req_duty_a = '0;
   logic [7:0] req_duty_b = '0;
   logic       inhibit_a = 1'b0;
   logic       inhibit_b = 1'b0;
   logic [7:0] duty_a, duty_b;
   logic       running_a, running_b, lockout_a, lockout_b, at_target_a, at_target_b;

   pump_ramp_scheduler #(
      .STEP_CYCLES    (STEP_CYCLES),
      .STEP_SIZE      (8'd10),
      .START_DUTY     (8'd77),
      .MIN_OFF_CYCLES (MIN_OFF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_duty_a  (req_duty_a),
      .req_duty_b  (req_duty_b),
      .inhibit_a   (inhibit_a),
      .inhibit_b   (inhibit_b),
      .duty_a      (duty_a),
      .duty_b      (duty_b),
      .running_a   (running_a),
      .running_b   (running_b),
      .lockout_a   (lockout_a),
      .lockout_b   (lockout_b),
      .at_target_a (at_target_a),
      .at_target_b (at_target_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      string       name;
      logic [21:0] exp;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   int          edges = 0;
   int          rel_edge = 0;
   logic [7:0]  md[2];
   logic [2:0]  mf[2];
   logic [21:0] act;

   assign act = {duty_a, running_a, lockout_a, at_target_a,
                 duty_b, running_b, lockout_b, at_target_b};

   task automatic drain(input int tag);
      exp_t e;
      while (q.size() > 0 && (q[0].cyc == tag || (tag >= 0 && q[0].cyc >= 0 && q[0].cyc < tag))) begin
         e = q.pop_front();
         checks++;
         if (e.cyc != tag) begin
            failures++;
            $display("FAIL %s: expectation for edge %0d was skipped (now edge %0d)", e.name, e.cyc, tag);
         end else if (act !== e.exp) begin
            failures++;
            $display("FAIL %s @edge %0d: got duty_a=%0d flags_a=%b duty_b=%0d flags_b=%b, expected duty_a=%0d flags_a=%b duty_b=%0d flags_b=%b",
                     e.name, tag, act[21:14], act[13:11], act[10:3], act[2:0],
                     e.exp[21:14], e.exp[13:11], e.exp[10:3], e.exp[2:0]);
         end
      end
   endtask

   // Monitor: synchronous expectations after each edge, asynchronous ones after reset rises.
   always @(posedge clk) begin
      edges++;
      #1;
      drain(edges);
   end

   always @(posedge reset) begin
      #1;
      drain(-1);
   end

   function automatic bit next_tick();
      return ((edges + 1 - rel_edge) % STEP_CYCLES) == 0;
   endfunction

   task automatic expect_next(input string name);
      exp_t e;
      e.cyc  = edges + 1;
      e.name = name;
      e.exp  = {md[0], mf[0], md[1], mf[1]};
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic ramp(input int ch, input string name, input logic [7:0] vals[$]);
      foreach (vals[i]) begin
         while (!next_tick()) expect_next(name);
         md[ch] = vals[i];
         expect_next(name);
      end
   endtask

   task automatic lockout_rest(input int ch, input string name);
      for (int i = 1; i < MIN_OFF; i++) expect_next(name);
      mf[ch] = F_IDLE;
      expect_next({name, "_idle"});
   endtask

   initial begin
      logic [7:0] t_up[$];
      logic [7:0] t_down[$];
      logic [7:0] t_ret[$];
      logic [7:0] t_down2[$];
      logic [7:0] t_b[$];
      logic [7:0] t_post[$];
      exp_t       ar;

      t_up    = '{8'd87, 8'd97, 8'd107, 8'd117, 8'd127, 8'd137, 8'd147, 8'd157,
                  8'd167, 8'd177, 8'd187, 8'd197, 8'd207, 8'd217, 8'd227, 8'd230};
      t_down  = '{8'd220, 8'd210, 8'd200, 8'd190, 8'd180, 8'd170, 8'd160, 8'd150,
                  8'd140, 8'd130, 8'd120};
      t_ret   = '{8'd130, 8'd140, 8'd150};
      t_down2 = '{8'd140, 8'd130, 8'd120, 8'd110, 8'd100, 8'd90, 8'd80, 8'd77};
      t_b     = '{8'd87, 8'd97, 8'd107, 8'd117, 8'd120};
      t_post  = '{8'd87, 8'd97};
      md[0] = '0; md[1] = '0; mf[0] = F_IDLE; mf[1] = F_IDLE;

      // 1: reset, then idle with zero requests
      @(negedge clk);
      expect_next("in_reset");
      reset = 1'b0;
      rel_edge = edges;
      repeat (3) expect_next("idle_after_reset");

      // 2: kick-start and ramp up with clamp at 230
      req_duty_a = 8'd230;
      md[0] = 8'd77; mf[0] = F_RAMP;
      expect_next("a_kick");
      ramp(0, "a_up", t_up);
      mf[0] = F_HOLD;
      expect_next("a_hold230");
      expect_next("a_hold230_steady");

      // 3: ramp down, retarget upward mid-ramp, then down to 77
      req_duty_a = 8'd77;
      mf[0] = F_RAMP;
      expect_next("a_hold_to_ramp");
      ramp(0, "a_down", t_down);
      req_duty_a = 8'd150;
      ramp(0, "a_retarget", t_ret);
      mf[0] = F_HOLD;
      expect_next("a_hold150");
      req_duty_a = 8'd77;
      mf[0] = F_RAMP;
      expect_next("a_hold_to_ramp2");
      ramp(0, "a_down2", t_down2);
      mf[0] = F_HOLD;
      expect_next("a_hold77");

      // 4: channel B at 120 ramping to 230, one-cycle inhibit pulse
      req_duty_b = 8'd120;
      md[1] = 8'd77; mf[1] = F_RAMP;
      expect_next("b_kick");
      ramp(1, "b_up", t_b);
      mf[1] = F_HOLD;
      expect_next("b_hold120");
      req_duty_b = 8'd230;
      mf[1] = F_RAMP;
      expect_next("b_ramp120");
      inhibit_b = 1'b1;
      md[1] = '0; mf[1] = F_LOCK;
      expect_next("b_inhibit");
      inhibit_b = 1'b0;
      lockout_rest(1, "b_lockout");
      md[1] = 8'd77; mf[1] = F_RAMP;
      expect_next("b_restart");

      // 5: stop B, then a request below the kick-start duty
      req_duty_b = 8'd0;
      md[1] = '0; mf[1] = F_LOCK;
      expect_next("b_stop");
      lockout_rest(1, "b_stop_lockout");
      expect_next("b_idle_stays");
      req_duty_b = 8'd40;
      md[1] = 8'd40; mf[1] = F_RAMP;
      expect_next("b_low_req");
      mf[1] = F_HOLD;
      expect_next("b_low_hold");
      repeat (5) expect_next("b_low_steady");

      // 6: async reset during A lockout, then restart
      req_duty_a = 8'd0;
      md[0] = '0; mf[0] = F_LOCK;
      expect_next("a_stop");
      repeat (4) expect_next("a_lockout");
      #2;
      md[0] = '0; md[1] = '0; mf[0] = F_IDLE; mf[1] = F_IDLE;
      ar.cyc = -1; ar.name = "async_reset"; ar.exp = '0;
      q.push_back(ar);
      reset = 1'b1;
      @(negedge clk);
      req_duty_a = 8'd200;
      expect_next("reset_hold");
      reset = 1'b0;
      rel_edge = edges;
      md[0] = 8'd77; mf[0] = F_RAMP;
      md[1] = 8'd40; mf[1] = F_RAMP;
      expect_next("post_reset_kick");
      mf[1] = F_HOLD;
      expect_next("post_reset_b_hold");
      ramp(0, "a_post", t_post);

      repeat (2) @(negedge clk);
      if (q.size() != 0) begin
         failures++;
         $display("FAIL leftover: %0d expectations never checked, required 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", edges);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pump_ramp_scheduler.md
Name: pump_ramp_scheduler

Overview:
Sits between filter_fsm and the PWM generators. It takes each pump's requested duty and produces the applied duty, rate-limiting changes with a shared step tick. Stopping or inhibiting a pump cuts it to zero at once and then enforces a minimum off-time before the next restart. The block has two identical channels: A (fill pump) and B (drain pump).

Parameters:
STEP_CYCLES, 500_000, clk cycles between ramp steps (10 ms @ 50 MHz); must be >= 1
STEP_SIZE, 8'd4, duty increment or decrement applied per step tick
START_DUTY, 8'd77, kick-start duty loaded on restart (equal to PWM_MIN)
MIN_OFF_CYCLES, 100_000_000, lockout length after any stop (2 s @ 50 MHz); must be >= 1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_duty_a  in  8  requested duty for pump A
req_duty_b  in  8  requested duty for pump B
inhibit_a  in  1  force pump A off (interlock, e.g. tank A full)
inhibit_b  in  1  force pump B off (dry-run, e.g. level_b_empty)
duty_a  out  8  applied duty for pump A, registered
duty_b  out  8  applied duty for pump B, registered
running_a / running_b  out  1 each  channel is in RAMP or HOLD
lockout_a / lockout_b  out  1 each  channel is in LOCKOUT
at_target_a / at_target_b  out  1 each  channel is in HOLD

Behaviour:
- Reset (asynchronous, any time): both channels go to IDLE. Duty is 0, all flags are 0, and the lockout counter is 0. No lockout runs after reset.
- Prescaler: one free-running counter shared by both channels, counting 0 to STEP_CYCLES-1. step_tick is high for one cycle when the count equals STEP_CYCLES-1, then the count wraps to 0. The prescaler resets to 0.
- Per-channel states:
  - IDLE: duty 0.
  - RAMP.
  - HOLD.
  - LOCKOUT: duty 0, off-time counter running.
- Priority in RAMP and HOLD, highest first: inhibit, then req == 0, then ramp/hold logic.
  - If inhibit is high or req == 0: go to LOCKOUT; duty becomes 0 on the same edge; counter clears.
- IDLE transitions:
  - If req != 0 and inhibit is low: go to RAMP; duty becomes min(START_DUTY, req) on that edge.
  - Otherwise stay in IDLE.
- RAMP:
  - Stepping happens only on step_tick cycles.
  - If duty < req: duty becomes min(duty + STEP_SIZE, req).
  - If duty > req: duty becomes max(duty − STEP_SIZE, req).
  - Do the arithmetic in 9 bits so there is no wrap past 255 or below 0.
  - When duty == req (registered compare): go to HOLD on the next edge. This does not wait for a tick.
- HOLD: if req != duty, go to RAMP. The target is sampled live, so changing req mid-ramp just retargets.
- LOCKOUT:
  - The counter increments every cycle.
  - When the counter reaches MIN_OFF_CYCLES-1: go to IDLE.
  - req and inhibit are ignored while in LOCKOUT.
  - A request that is still pending restarts the channel from IDLE one cycle later.
- Latency: every output is registered. Apart from stepping, a change on an input shows on the outputs at the next clk edge.
- Channels are independent; they share only step_tick, and both may step on the same tick.
- Boundary cases:
  - req below START_DUTY: duty goes straight to req, then HOLD.
  - req == 255 with STEP_SIZE overshoot: clamp to 255.
  - inhibit pulsed for 1 cycle: the full lockout still applies.
  - Reset during LOCKOUT cancels the lockout.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit.

Decomposition:
- Package pump_ctrl_pkg:
  - PWM_MIN = 77 and PWM_MAX = 230, also used by filter_fsm.
  - Enum ramp_state_t {IDLE, RAMP, HOLD, LOCKOUT}, 2 bits.
- Sub-module pump_ramp_channel, instantiated twice. Parameters: STEP_SIZE, START_DUTY, MIN_OFF_CYCLES. Ports: clk, reset, step_tick, req_duty, inhibit, duty, running, lockout, at_target.
- The top level holds only the prescaler and the two instances.

Test Plan:
Use STEP_CYCLES=4, STEP_SIZE=10, START_DUTY=77, MIN_OFF_CYCLES=20; the bench syncs to step_tick.
1. Reset asserted then released with requests 0 -> all duties 0, all flags 0. Assert reset mid-cycle -> outputs clear immediately (asynchronous).
2. req_duty_a 0 -> 230 -> next edge duty_a = 77 and running_a = 1. Each tick then steps 87, 97, ..., 227, 230 (clamped). at_target_a = 1 on the edge after reaching 230.
3. From HOLD at 230, req_duty_a = 77 -> duty steps 220, 210, ..., 80, 77, then HOLD. Retarget to 150 mid-ramp -> duty turns upward toward 150 from its current value.
4. Channel B ramping at 120 with req 230, pulse inhibit_b for 1 cycle -> duty_b = 0 and lockout_b = 1 on the next edge for exactly 20 cycles. Then IDLE, then duty_b = 77 the following edge. Channel A is unaffected throughout.
5. req_duty_b = 40 (below START_DUTY) -> duty_b = 40 on the next edge, then HOLD, with no stepping.
6. Reset asserted during lockout_a -> lockout cleared. After reset is released with req_duty_a = 200 -> duty_a = 77 on the first edge.
